// File: rtl/iserdes_pkg.sv
// iserdes_pkg: shared FSM states, default parameters and slip-count width helper.
package iserdes_pkg;
  typedef enum logic [2:0] {IDLE, SEARCH, SETTLE, VERIFY, LOCKED, FAILED} state_t;
  localparam int DEF_WIDTH = 10;
  localparam logic [9:0] DEF_TRAIN_PATTERN = 10'b1111100000;
  localparam int DEF_LOCK_COUNT = 4;
  function automatic int slip_w(input int max_slips);
    return $clog2(max_slips + 1);
  endfunction
endpackage

// File: rtl/iserdes_shift_capture.sv
// iserdes_shift_capture: serial shift register, word boundary counter with one-cycle slip hold.
module iserdes_shift_capture #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             data_i,
  input  logic             slip,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [WIDTH-1:0] sr, sr_nx;
  logic [CW-1:0] bit_cnt;
  logic pend, hold, wrap;
  always_comb begin
    hold = pend || slip;
    wrap = !hold && bit_cnt == LAST;
    sr_nx = {sr[WIDTH-2:0], data_i};
  end
  // a slip arriving while another is still pending is absorbed by the same hold
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sr <= '0;
      bit_cnt <= '0;
      pend <= 1'b0;
      word_o <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= en && wrap;
      if (en) begin
        sr <= sr_nx;
        bit_cnt <= hold ? bit_cnt : wrap ? '0 : bit_cnt + 1'b1;
        pend <= 1'b0;
        if (wrap) word_o <= sr_nx;
      end else pend <= hold;
    end
endmodule

// File: rtl/iserdes_autoalign.sv
// iserdes_autoalign: deserialiser that slips its word boundary until the training pattern locks.
module iserdes_autoalign import iserdes_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(DEF_TRAIN_PATTERN),
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int MAX_SLIPS = WIDTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable_n,
  input  logic                             data_i,
  input  logic                             bitslip_n,
  input  logic                             retrain,
  output logic [WIDTH-1:0]                 word_o,
  output logic                             word_valid,
  output logic                             ready,
  output logic                             align_err,
  output logic [slip_w(MAX_SLIPS)-1:0]     slip_cnt
);
  localparam int SW = slip_w(MAX_SLIPS);
  localparam logic [SW-1:0] MS = SW'(MAX_SLIPS);
  localparam logic [8:0] LC = 9'(LOCK_COUNT);
  state_t state;
  logic [7:0] match_cnt;
  logic slip_req, bs_q, match, at_max;
  iserdes_shift_capture #(.WIDTH(WIDTH)) u_cap (
    .clk(clk),
    .reset_n(reset_n),
    .en(!enable_n),
    .data_i(data_i),
    .slip(slip_req),
    .word_o(word_o),
    .word_valid(word_valid)
  );
  always_comb begin
    match = word_o == TRAIN_PATTERN;
    at_max = slip_cnt == MS;
  end
  // slip_req is a one-cycle pulse; the capture block turns it into a one-cycle counter hold
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      match_cnt <= '0;
      slip_cnt <= '0;
      slip_req <= 1'b0;
      ready <= 1'b0;
      align_err <= 1'b0;
      bs_q <= 1'b1;
    end else begin
      bs_q <= bitslip_n;
      slip_req <= 1'b0;
      if (retrain || enable_n) begin
        state <= IDLE;
        match_cnt <= '0;
        slip_cnt <= '0;
        ready <= 1'b0;
        align_err <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= SEARCH;
            slip_cnt <= '0;
            match_cnt <= '0;
          end
          SEARCH: if (word_valid) begin
            if (match) begin
              match_cnt <= 8'd1;
              state <= LC <= 9'd1 ? LOCKED : VERIFY;
              ready <= LC <= 9'd1;
            end else if (at_max) begin
              state <= FAILED;
              align_err <= 1'b1;
            end else begin
              slip_req <= 1'b1;
              slip_cnt <= slip_cnt + 1'b1;
              state <= SETTLE;
            end
          end
          SETTLE: if (word_valid) state <= SEARCH;
          VERIFY: if (word_valid) begin
            if (match) begin
              match_cnt <= match_cnt + 1'b1;
              if ({1'b0, match_cnt} + 9'd1 >= LC) begin
                state <= LOCKED;
                ready <= 1'b1;
              end
            end else if (at_max) begin
              state <= FAILED;
              align_err <= 1'b1;
            end else begin
              slip_req <= 1'b1;
              slip_cnt <= slip_cnt + 1'b1;
              state <= SEARCH;
            end
          end
          LOCKED: if (bs_q && !bitslip_n) begin
            slip_req <= 1'b1;
            slip_cnt <= at_max ? slip_cnt : slip_cnt + 1'b1;
          end
          FAILED: state <= FAILED;
          default: state <= IDLE;
        endcase
      end
    end
endmodule
